// File: rtl/tsc_isa_pkg.sv
// TSC ISA encodings shared by the multi-cycle control FSM and the ALU control unit:
// opcodes, R-type functs, FSM states, control-field codes and an instruction classifier.
package tsc_isa_pkg;

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_ALU_MAX = 6'd7;
  localparam logic [5:0] FN_JPR     = 6'd25;
  localparam logic [5:0] FN_JRL     = 6'd26;
  localparam logic [5:0] FN_WWD     = 6'd28;
  localparam logic [5:0] FN_HLT     = 6'd29;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    DST_RT = 2'b00,
    DST_RD = 2'b01,
    DST_R2 = 2'b10
  } reg_dst_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MDR = 2'b01,
    WB_PC1 = 2'b10
  } wb_src_e;

  typedef enum logic [1:0] {
    PC_PLUS1  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RS     = 2'b11
  } pc_src_e;

  typedef enum logic [3:0] {
    CL_NOP, CL_ALU, CL_IMM, CL_LWD, CL_SWD, CL_BR,
    CL_JMP, CL_JAL, CL_JPR, CL_JRL, CL_WWD, CL_HLT
  } iclass_e;

  function automatic iclass_e decode_class(input logic [3:0] op, input logic [5:0] fn);
    iclass_e cls;
    cls = CL_NOP;
    case (op)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: cls = CL_BR;
      OP_ADI, OP_ORI, OP_LHI:         cls = CL_IMM;
      OP_LWD:                         cls = CL_LWD;
      OP_SWD:                         cls = CL_SWD;
      OP_JMP:                         cls = CL_JMP;
      OP_JAL:                         cls = CL_JAL;
      OP_RTYPE: begin
        if (fn <= FN_ALU_MAX) begin
          cls = CL_ALU;
        end else begin
          case (fn)
            FN_JPR:  cls = CL_JPR;
            FN_JRL:  cls = CL_JRL;
            FN_WWD:  cls = CL_WWD;
            FN_HLT:  cls = CL_HLT;
            default: cls = CL_NOP;
          endcase
        end
      end
      default: cls = CL_NOP;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/inst_retire_counter.sv
// Retired-instruction counter: increments by one when enabled, wraps at 2**CNT_W.
module inst_retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM for the TSC CPU: sequences FETCH/DECODE/EXEC/MEM/WB, latches HALT.
// Strobes decode from state, opcode/funct and mem_ready; halted and num_inst are registered.
module mc_control_fsm
  import tsc_isa_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             bcond,
  input  logic             mem_ready,
  output logic             alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_src,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             is_wwd,
  output logic             halted,
  output logic [CNT_W-1:0] num_inst
);

  state_e  state_q, state_d;
  logic    halted_q, halted_d;
  logic    retire_en;
  iclass_e cls;
  logic    unused_bcond;

  assign cls = decode_class(opcode, funct);
  // bcond qualifies pc_write_cond inside the datapath; the sequencing never depends on it.
  assign unused_bcond = bcond;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    halted_d      = halted_q;
    alu_op        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = DST_RT;
    wb_src        = WB_ALU;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PC_PLUS1;
    is_wwd        = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (cls)
          CL_HLT: begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
          CL_JMP: begin
            pc_write  = 1'b1;
            pc_source = PC_JUMP;
            state_d   = ST_FETCH;
          end
          CL_JAL: begin
            pc_write  = 1'b1;
            pc_source = PC_JUMP;
            reg_write = 1'b1;
            reg_dst   = DST_R2;
            wb_src    = WB_PC1;
            state_d   = ST_FETCH;
          end
          CL_NOP:  state_d = ST_FETCH;
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (cls)
          CL_ALU, CL_IMM: begin
            alu_op  = 1'b1;
            state_d = ST_WB;
          end
          CL_LWD, CL_SWD: begin
            alu_op  = 1'b1;
            state_d = ST_MEM;
          end
          CL_BR: begin
            pc_write_cond = 1'b1;
            pc_source     = PC_BRANCH;
          end
          CL_JPR: begin
            pc_write  = 1'b1;
            pc_source = PC_RS;
          end
          CL_JRL: begin
            pc_write  = 1'b1;
            pc_source = PC_RS;
            reg_write = 1'b1;
            reg_dst   = DST_R2;
            wb_src    = WB_PC1;
          end
          CL_WWD:  is_wwd = 1'b1;
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        i_or_d = 1'b1;
        if (cls == CL_LWD) begin
          mem_read = 1'b1;
          if (mem_ready) state_d = ST_WB;
        end else begin
          mem_write = 1'b1;
          if (mem_ready) state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        reg_dst   = (cls == CL_ALU) ? DST_RD : DST_RT;
        wb_src    = (cls == CL_LWD) ? WB_MDR : WB_ALU;
        state_d   = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase

    // State already sits in FETCH during reset; keep every strobe quiet until release.
    if (reset) begin
      alu_op        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = DST_RT;
      wb_src        = WB_ALU;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = PC_PLUS1;
      is_wwd        = 1'b0;
    end
  end

  assign retire_en = ((state_d == ST_FETCH) && (state_q != ST_FETCH)) ||
                     ((state_d == ST_HALT)  && (state_q != ST_HALT));
  assign halted    = halted_q;

  inst_retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire (
    .clk    (clk),
    .reset  (reset),
    .inc_en (retire_en),
    .count  (num_inst)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: table of per-instruction latencies, hand-written corner sequences,
// and random instruction streams checked cycle by cycle against a phase-level model.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       is_wwd;
    logic       halted;
  } outs_t;

  typedef enum int {K_NOP, K_ALU, K_IMM, K_LWD, K_SWD, K_BR,
                    K_JMP, K_JAL, K_JPR, K_JRL, K_WWD, K_HLT} kind_e;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [5:0] fn;
    logic       bc;
    int         cycles;
    outs_t      last;
  } vec_t;

  logic clk = 1'b0;
  logic reset, bcond, mem_ready;
  logic [3:0] opcode;
  logic [5:0] funct;

  logic alu_op, mem_read, mem_write, i_or_d, ir_write, reg_write;
  logic [1:0] reg_dst, wb_src, pc_source;
  logic pc_write, pc_write_cond, is_wwd, halted;
  logic [15:0] num_inst;

  logic w4_alu_op, w4_mem_read, w4_mem_write, w4_i_or_d, w4_ir_write, w4_reg_write;
  logic [1:0] w4_reg_dst, w4_wb_src, w4_pc_source;
  logic w4_pc_write, w4_pc_write_cond, w4_is_wwd, w4_halted;
  logic [3:0] num_inst4;

  outs_t act, act4;
  int n_cmp = 0;
  int n_fail = 0;
  int cnt = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .bcond(bcond),
    .mem_ready(mem_ready), .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .wb_src(wb_src), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .is_wwd(is_wwd), .halted(halted), .num_inst(num_inst)
  );

  // Narrow-counter twin sees the same stream so counter wrap is reached quickly.
  mc_control_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .bcond(bcond),
    .mem_ready(mem_ready), .alu_op(w4_alu_op), .mem_read(w4_mem_read),
    .mem_write(w4_mem_write), .i_or_d(w4_i_or_d), .ir_write(w4_ir_write),
    .reg_write(w4_reg_write), .reg_dst(w4_reg_dst), .wb_src(w4_wb_src),
    .pc_write(w4_pc_write), .pc_write_cond(w4_pc_write_cond), .pc_source(w4_pc_source),
    .is_wwd(w4_is_wwd), .halted(w4_halted), .num_inst(num_inst4)
  );

  assign act  = {alu_op, mem_read, mem_write, i_or_d, ir_write, reg_write, reg_dst,
                 wb_src, pc_write, pc_write_cond, pc_source, is_wwd, halted};
  assign act4 = {w4_alu_op, w4_mem_read, w4_mem_write, w4_i_or_d, w4_ir_write, w4_reg_write,
                 w4_reg_dst, w4_wb_src, w4_pc_write, w4_pc_write_cond, w4_pc_source,
                 w4_is_wwd, w4_halted};

  function automatic kind_e classify(input logic [3:0] op, input logic [5:0] fn);
    if (op <= 4'd3) return K_BR;
    if (op >= 4'd4 && op <= 4'd6) return K_IMM;
    if (op == 4'd7) return K_LWD;
    if (op == 4'd8) return K_SWD;
    if (op == 4'd9) return K_JMP;
    if (op == 4'd10) return K_JAL;
    if (op == 4'd15) begin
      if (fn <= 6'd7) return K_ALU;
      if (fn == 6'd25) return K_JPR;
      if (fn == 6'd26) return K_JRL;
      if (fn == 6'd28) return K_WWD;
      if (fn == 6'd29) return K_HLT;
    end
    return K_NOP;
  endfunction

  function automatic outs_t o_wb(input logic [1:0] dst, input logic [1:0] src);
    outs_t o = '0;
    o.reg_write = 1'b1; o.reg_dst = dst; o.wb_src = src;
    return o;
  endfunction

  function automatic outs_t o_pc(input logic [1:0] src, input logic link);
    outs_t o = '0;
    o.pc_write = 1'b1; o.pc_source = src;
    if (link) begin o.reg_write = 1'b1; o.reg_dst = 2'b10; o.wb_src = 2'b10; end
    return o;
  endfunction

  function automatic outs_t o_misc(input kind_e k);
    outs_t o = '0;
    if (k == K_BR) begin o.pc_write_cond = 1'b1; o.pc_source = 2'b01; end
    if (k == K_WWD) o.is_wwd = 1'b1;
    if (k == K_SWD) begin o.mem_write = 1'b1; o.i_or_d = 1'b1; end
    return o;
  endfunction

  task automatic chk_o(input string nm, input outs_t a, input outs_t e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic chk_n(input string nm, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // One clock cycle: drive at negedge, compare 1 time unit later, advance to next negedge.
  task automatic step(input logic mr, input outs_t e, input string nm);
    mem_ready = mr;
    bcond = 1'($urandom_range(0, 1));
    #1;
    chk_o(nm, act, e);
    chk_o({nm, "/w4"}, act4, e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    #1;
    chk_o("reset_strobes", act, '0);
    chk_n("reset_num_inst", int'(num_inst), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
  endtask

  // Expected per-cycle outputs of one instruction, built from its phase list.
  task automatic run_inst(input logic [3:0] op, input logic [5:0] fn, input int fst,
                          input int mst, input string tag);
    kind_e k;
    outs_t o;
    k = classify(op, fn);
    opcode = op;
    funct = fn;
    for (int i = 0; i < fst; i++) begin
      o = '0; o.mem_read = 1'b1;
      step(1'b0, o, {tag, ":fetch_wait"});
    end
    o = '0; o.mem_read = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    step(1'b1, o, {tag, ":fetch"});
    o = '0;
    if (k == K_JMP) o = o_pc(2'b10, 1'b0);
    if (k == K_JAL) o = o_pc(2'b10, 1'b1);
    step(1'($urandom_range(0, 1)), o, {tag, ":decode"});
    if (k inside {K_JMP, K_JAL, K_NOP, K_HLT}) return;
    o = o_misc(k);
    if (k == K_SWD) o = '0;
    if (k inside {K_ALU, K_IMM, K_LWD, K_SWD}) o.alu_op = 1'b1;
    if (k == K_JPR) o = o_pc(2'b11, 1'b0);
    if (k == K_JRL) o = o_pc(2'b11, 1'b1);
    step(1'($urandom_range(0, 1)), o, {tag, ":exec"});
    if (k inside {K_BR, K_JPR, K_JRL, K_WWD}) return;
    if (k inside {K_LWD, K_SWD}) begin
      o = '0; o.i_or_d = 1'b1;
      o.mem_read = (k == K_LWD);
      o.mem_write = (k == K_SWD);
      for (int i = 0; i < mst; i++) step(1'b0, o, {tag, ":mem_wait"});
      step(1'b1, o, {tag, ":mem"});
      if (k == K_SWD) return;
    end
    o = o_wb((k == K_ALU) ? 2'b01 : 2'b00, (k == K_LWD) ? 2'b01 : 2'b00);
    step(1'($urandom_range(0, 1)), o, {tag, ":wb"});
  endtask

  task automatic do_inst(input logic [3:0] op, input logic [5:0] fn, input int fst,
                         input int mst, input int hold, input string tag);
    outs_t o;
    run_inst(op, fn, fst, mst, tag);
    cnt++;
    chk_n({tag, ":num_inst"}, int'(num_inst), cnt % 65536);
    chk_n({tag, ":num_inst_w4"}, int'(num_inst4), cnt % 16);
    if (classify(op, fn) == K_HLT) begin
      o = '0; o.halted = 1'b1;
      for (int i = 0; i < hold; i++) step(1'($urandom_range(0, 1)), o, {tag, ":halt"});
      chk_n({tag, ":halt_num_inst"}, int'(num_inst), cnt % 65536);
    end
  endtask

  initial begin
    vec_t tbl[$];
    outs_t o, last;
    int n;
    logic [3:0] rop;
    logic [5:0] rfn;

    reset = 1'b1; opcode = '0; funct = '0; bcond = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Latency and final-cycle strobes per instruction with mem_ready held high.
    tbl.push_back('{"ADD",   4'd15, 6'd0,  1'b0, 4, o_wb(2'b01, 2'b00)});
    tbl.push_back('{"ADI",   4'd4,  6'd0,  1'b0, 4, o_wb(2'b00, 2'b00)});
    tbl.push_back('{"LHI",   4'd6,  6'd17, 1'b0, 4, o_wb(2'b00, 2'b00)});
    tbl.push_back('{"LWD",   4'd7,  6'd0,  1'b0, 5, o_wb(2'b00, 2'b01)});
    tbl.push_back('{"SWD",   4'd8,  6'd0,  1'b0, 4, o_misc(K_SWD)});
    tbl.push_back('{"BEQ_T", 4'd1,  6'd0,  1'b1, 3, o_misc(K_BR)});
    tbl.push_back('{"BEQ_N", 4'd1,  6'd0,  1'b0, 3, o_misc(K_BR)});
    tbl.push_back('{"BLZ",   4'd3,  6'd0,  1'b1, 3, o_misc(K_BR)});
    tbl.push_back('{"JPR",   4'd15, 6'd25, 1'b0, 3, o_pc(2'b11, 1'b0)});
    tbl.push_back('{"JRL",   4'd15, 6'd26, 1'b0, 3, o_pc(2'b11, 1'b1)});
    tbl.push_back('{"WWD",   4'd15, 6'd28, 1'b0, 3, o_misc(K_WWD)});
    tbl.push_back('{"JMP",   4'd9,  6'd0,  1'b0, 2, o_pc(2'b10, 1'b0)});
    tbl.push_back('{"JAL",   4'd10, 6'd0,  1'b0, 2, o_pc(2'b10, 1'b1)});
    tbl.push_back('{"UNDOP", 4'd12, 6'd0,  1'b0, 2, '0});
    tbl.push_back('{"UNDFN", 4'd15, 6'd40, 1'b0, 2, '0});
    tbl.push_back('{"HLT",   4'd15, 6'd29, 1'b0, 2, '0});

    foreach (tbl[i]) begin
      do_reset();
      opcode = tbl[i].op; funct = tbl[i].fn; bcond = tbl[i].bc; mem_ready = 1'b1;
      n = 0;
      last = '0;
      #1;
      while (n < 12) begin
        last = act;
        n++;
        @(posedge clk);
        @(negedge clk);
        #1;
        if ((act.mem_read && !act.i_or_d) || act.halted) break;
      end
      chk_n({tbl[i].name, ":cycles"}, n, tbl[i].cycles);
      chk_o({tbl[i].name, ":last_cycle"}, last, tbl[i].last);
      chk_n({tbl[i].name, ":retired"}, int'(num_inst), 1);
    end

    // LWD stalled three cycles in MEM, ADD first so the count starts non-zero.
    do_reset();
    do_inst(4'd15, 6'd0, 0, 0, 0, "add");
    do_inst(4'd7, 6'd0, 0, 3, 0, "lwd_stall");
    do_inst(4'd8, 6'd0, 2, 1, 0, "swd_stall");

    // Halt stays absorbing for 20 cycles and retires once.
    do_reset();
    do_inst(4'd15, 6'd29, 0, 0, 20, "hlt");

    // Reset in the middle of a SWD memory wait abandons it.
    do_reset();
    do_inst(4'd9, 6'd0, 0, 0, 0, "jmp_pre");
    opcode = 4'd8; funct = 6'd0;
    o = '0; o.mem_read = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    step(1'b1, o, "swd_rst:fetch");
    step(1'b1, '0, "swd_rst:decode");
    o = '0; o.alu_op = 1'b1;
    step(1'b1, o, "swd_rst:exec");
    step(1'b0, o_misc(K_SWD), "swd_rst:mem_wait");
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk_o("swd_rst:strobes_in_reset", act, '0);
    chk_n("swd_rst:num_inst", int'(num_inst), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    do_inst(4'd9, 6'd0, 1, 0, 0, "post_rst_jmp");

    // Back-to-back jumps push the narrow counter through several wraps.
    do_reset();
    for (int i = 0; i < 40; i++) do_inst(4'd9, 6'(i), 0, 0, 0, "jmp_wrap");
    do_inst(4'd10, 6'd3, 0, 0, 0, "jal");

    // Random instruction stream with random handshake stalls.
    do_reset();
    for (int i = 0; i < 250; i++) begin
      rop = 4'($urandom_range(0, 15));
      rfn = 6'($urandom_range(0, 63));
      if (rop == 4'd15) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: rfn = 6'($urandom_range(0, 7));
          4: rfn = 6'd25;
          5: rfn = 6'd26;
          6: rfn = 6'd28;
          7: rfn = 6'd29;
          default: rfn = 6'($urandom_range(8, 63));
        endcase
      end
      do_inst(rop, rfn, $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(1, 4), "rand");
      if (classify(rop, rfn) == K_HLT) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
